chip_access_driver: RTL and testbench

Command-side driver for the `Chip` memory model: accepts DRAM-style commands (ACT, RD, WR, PRE) over a valid/ready handshake, tracks the open row of every bank, and sequences BL8 bursts onto the Chip's per-bank `rd_o_wr`/`row`/`column`/`dqin` arrays. It collects the matching `dqout` beats into a read-data stream. It sits between the memory controller front end and `Chip`, and performs the addressing, state and data-synchronisation work that the Chip model leaves outside the device.

---
 rtl/chip_access_driver.sv | 182 ++++++++++++++++++
 tb/tb_chip_access_driver.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/chip_access_driver.sv
// Command-side driver for the Chip memory model: per-bank open-row tracking,
// sequential BL8 burst sequencing onto the per-bank arrays, and read-data return.
module chip_access_driver #(
  parameter int BGWIDTH       = 2,
  parameter int BANKGROUPS    = 2**BGWIDTH,
  parameter int BAWIDTH       = 2,
  parameter int BANKSPERGROUP = 2**BAWIDTH,
  parameter int COLWIDTH      = 10,
  parameter int DEVICE_WIDTH  = 4,
  parameter int CHWIDTH       = 5,
  parameter int RD_LAT        = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic [BGWIDTH-1:0]      cmd_bg,
  input  logic [BAWIDTH-1:0]      cmd_ba,
  input  logic [CHWIDTH-1:0]      cmd_row,
  input  logic [COLWIDTH-1:0]     cmd_col,
  output logic                    cmd_err,
  input  logic [DEVICE_WIDTH-1:0] wdata,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [DEVICE_WIDTH-1:0] rdata,
  output logic                    rvalid,
  output logic                    rd_o_wr [BANKGROUPS][BANKSPERGROUP],
  output logic [DEVICE_WIDTH-1:0] dqin    [BANKGROUPS][BANKSPERGROUP],
  input  logic [DEVICE_WIDTH-1:0] dqout   [BANKGROUPS][BANKSPERGROUP],
  output logic [CHWIDTH-1:0]      row     [BANKGROUPS][BANKSPERGROUP],
  output logic [COLWIDTH-1:0]     column  [BANKGROUPS][BANKSPERGROUP]
);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_DRAIN} state_e;

  localparam logic [1:0] OP_ACT = 2'd0;
  localparam logic [1:0] OP_PRE = 2'd3;

  state_e                    state_q, state_d;
  logic [BGWIDTH-1:0]        bg_q, bg_d;
  logic [BAWIDTH-1:0]        ba_q, ba_d;
  logic [COLWIDTH-1:0]       col_q, col_d;
  logic                      wr_q, wr_d;
  logic [2:0]                k_q, k_d;
  logic [2:0]                rcnt_q, rcnt_d;
  logic                      err_q, err_d;
  logic [RD_LAT-1:0]         vld_line_q;
  logic                      rvalid_q;
  logic [DEVICE_WIDTH-1:0]   rdata_q;
  logic                      open_q     [BANKGROUPS][BANKSPERGROUP];
  logic [CHWIDTH-1:0]        open_row_q [BANKGROUPS][BANKSPERGROUP];
  logic [COLWIDTH-1:0]       column_q   [BANKGROUPS][BANKSPERGROUP];
  logic [DEVICE_WIDTH-1:0]   dqin_q     [BANKGROUPS][BANKSPERGROUP];
  logic                      tgt_open, act_ok, pre_acc, start, issue, wr_beat, advance;

  // Sequential BL8: the low three column bits wrap inside the 8-aligned block.
  function automatic logic [COLWIDTH-1:0] beat_col(input logic [COLWIDTH-1:0] col,
                                                   input logic [2:0] k);
    beat_col = {col[COLWIDTH-1:3], col[2:0] + k};
  endfunction

  always_comb begin
    state_d  = state_q;
    bg_d     = bg_q;
    ba_d     = ba_q;
    col_d    = col_q;
    wr_d     = wr_q;
    k_d      = k_q;
    err_d    = 1'b0;
    act_ok   = 1'b0;
    pre_acc  = 1'b0;
    start    = 1'b0;
    issue    = 1'b0;
    wr_beat  = 1'b0;
    advance  = 1'b0;
    tgt_open = open_q[cmd_bg][cmd_ba];
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_op == OP_ACT) begin
            if (tgt_open) err_d = 1'b1;
            else          act_ok = 1'b1;
          end else if (cmd_op == OP_PRE) begin
            pre_acc = 1'b1;
          end else if (!tgt_open) begin
            err_d = 1'b1;
          end else begin
            start   = 1'b1;
            bg_d    = cmd_bg;
            ba_d    = cmd_ba;
            col_d   = cmd_col;
            wr_d    = cmd_op[1];
            k_d     = 3'd0;
            state_d = S_BURST;
          end
        end
      end
      S_BURST: begin
        issue   = !wr_q;
        wr_beat = wr_q && wvalid;
        advance = issue || wr_beat;
        if (advance) begin
          if (k_q == 3'd7) state_d = wr_q ? S_IDLE : S_DRAIN;
          else             k_d = k_q + 3'd1;
        end
      end
      S_DRAIN: begin
        if (rvalid_q && rcnt_q == 3'd7) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (start)         rcnt_d = 3'd0;
    else if (rvalid_q) rcnt_d = rcnt_q + 3'd1;
    else               rcnt_d = rcnt_q;
  end

  always_comb begin
    cmd_ready = (state_q == S_IDLE) && !rst;
    wready    = (state_q == S_BURST) && wr_q;
    cmd_err   = err_q;
    rvalid    = rvalid_q;
    rdata     = rdata_q;
    for (int g = 0; g < BANKGROUPS; g++) begin
      for (int b = 0; b < BANKSPERGROUP; b++) begin
        rd_o_wr[g][b] = wr_beat && (bg_q == BGWIDTH'(g)) && (ba_q == BAWIDTH'(b));
        dqin[g][b]    = rd_o_wr[g][b] ? wdata : dqin_q[g][b];
        row[g][b]     = open_row_q[g][b];
        column[g][b]  = column_q[g][b];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bg_q       <= '0;
      ba_q       <= '0;
      col_q      <= '0;
      wr_q       <= 1'b0;
      k_q        <= '0;
      rcnt_q     <= '0;
      err_q      <= 1'b0;
      vld_line_q <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      for (int g = 0; g < BANKGROUPS; g++) begin
        for (int b = 0; b < BANKSPERGROUP; b++) begin
          open_q[g][b]     <= 1'b0;
          open_row_q[g][b] <= '0;
          column_q[g][b]   <= '0;
          dqin_q[g][b]     <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      bg_q    <= bg_d;
      ba_q    <= ba_d;
      col_q   <= col_d;
      wr_q    <= wr_d;
      k_q     <= k_d;
      rcnt_q  <= rcnt_d;
      err_q   <= err_d;
      // Read return: valid line matches Chip latency, then one register stage.
      for (int i = RD_LAT - 1; i > 0; i--) vld_line_q[i] <= vld_line_q[i-1];
      vld_line_q[0] <= issue;
      rvalid_q      <= vld_line_q[RD_LAT-1];
      if (vld_line_q[RD_LAT-1]) rdata_q <= dqout[bg_q][ba_q];
      if (act_ok) begin
        open_q[cmd_bg][cmd_ba]     <= 1'b1;
        open_row_q[cmd_bg][cmd_ba] <= cmd_row;
      end
      if (pre_acc) open_q[cmd_bg][cmd_ba] <= 1'b0;
      if (start)
        column_q[cmd_bg][cmd_ba] <= cmd_col;
      else if (advance && k_q != 3'd7)
        column_q[bg_q][ba_q] <= beat_col(col_q, k_q + 3'd1);
      if (wr_beat) dqin_q[bg_q][ba_q] <= wdata;
    end
  end

endmodule

// File: tb/tb_chip_access_driver.sv
// Directed bench for chip_access_driver with a small behavioural Chip model
// (RD_LAT = 1) attached to the per-bank arrays.
module tb_chip_access_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [1:0] cmd_bg;
  logic [1:0] cmd_ba;
  logic [4:0] cmd_row;
  logic [9:0] cmd_col;
  logic       cmd_err;
  logic [3:0] wdata;
  logic       wvalid;
  logic       wready;
  logic [3:0] rdata;
  logic       rvalid;
  logic       rd_o_wr [4][4];
  logic [3:0] dqin    [4][4];
  logic [3:0] dqout   [4][4];
  logic [4:0] row     [4][4];
  logic [9:0] column  [4][4];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  logic [3:0] mem [int];
  logic [3:0] rq [$];
  int         rc [$];

  logic [9:0] col_a [8] = '{10'h3FA, 10'h3FB, 10'h3FC, 10'h3FD, 10'h3FE, 10'h3FF, 10'h3F8, 10'h3F9};
  logic [9:0] col_b [8] = '{10'h015, 10'h016, 10'h017, 10'h010, 10'h011, 10'h012, 10'h013, 10'h014};
  logic [3:0] dat_a [8] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
  logic [3:0] dat_b [8] = '{4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h1};

  chip_access_driver dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_bg(cmd_bg), .cmd_ba(cmd_ba), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .cmd_err(cmd_err), .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .rdata(rdata), .rvalid(rvalid), .rd_o_wr(rd_o_wr), .dqin(dqin),
    .dqout(dqout), .row(row), .column(column)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int mkey(int g, int b, int r, int c);
    return (((g * 4 + b) * 32 + r) * 1024 + c);
  endfunction

  // Chip model: writes land on the edge, reads return one cycle after column.
  always @(posedge clk) begin
    for (int g = 0; g < 4; g++) begin
      for (int b = 0; b < 4; b++) begin
        int k;
        k = mkey(g, b, int'(row[g][b]), int'(column[g][b]));
        if (rd_o_wr[g][b] === 1'b1) mem[k] = dqin[g][b];
        dqout[g][b] <= mem.exists(k) ? mem[k] : 4'h0;
      end
    end
  end

  always @(negedge clk) begin
    if (rvalid === 1'b1) begin
      rq.push_back(rdata);
      rc.push_back(cyc);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] g, input logic [1:0] b,
                       input logic [4:0] r, input logic [9:0] c);
    cmd_op = op; cmd_bg = g; cmd_ba = b; cmd_row = r; cmd_col = c;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_ready(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (cmd_ready === 1'b1) break;
      step();
    end
  endtask

  task automatic rd_burst(input string tag, input logic [9:0] c, input logic [3:0] exp [8]);
    int n0;
    rq.delete();
    rc.delete();
    issue(2'd1, 2'd1, 2'd2, 5'd0, c);
    n0 = cyc;
    wait_ready(30);
    check_eq({tag, "_ready"}, cmd_ready, 1);
    check_eq({tag, "_ready_cyc"}, cyc, n0 + 10);
    check_eq({tag, "_nbeats"}, rq.size(), 8);
    for (int k = 0; k < 8 && k < rq.size(); k++) begin
      check_eq({tag, "_data"}, rq[k], exp[k]);
      check_eq({tag, "_cyc"}, rc[k], n0 + 2 + k);
    end
  endtask

  initial begin
    int n_before;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_bg = 2'd0; cmd_ba = 2'd0;
    cmd_row = 5'd0; cmd_col = 10'd0; wdata = 4'd0; wvalid = 1'b0;
    repeat (3) step();
    check_eq("rst_ready", cmd_ready, 0);
    check_eq("rst_rvalid", rvalid, 0);
    check_eq("rst_err", cmd_err, 0);
    check_eq("rst_wready", wready, 0);
    check_eq("rst_row", row[1][2], 0);
    check_eq("rst_col", column[1][2], 0);
    rst = 1'b0;
    #1;
    check_eq("ready_after_rst", cmd_ready, 1);

    // ACT bg1/ba2 row 5
    issue(2'd0, 2'd1, 2'd2, 5'd5, 10'd0);
    check_eq("act_row", row[1][2], 5);
    check_eq("act_err", cmd_err, 0);
    check_eq("act_ready", cmd_ready, 1);

    // WR col 0x3FA, wvalid held high
    issue(2'd2, 2'd1, 2'd2, 5'd0, 10'h3FA);
    for (int i = 0; i < 8; i++) begin
      wvalid = 1'b1;
      wdata  = dat_a[i];
      #1;
      check_eq("wr_col", column[1][2], col_a[i]);
      check_eq("wr_rdowr", rd_o_wr[1][2], 1);
      check_eq("wr_dqin", dqin[1][2], dat_a[i]);
      check_eq("wr_wready", wready, 1);
      check_eq("wr_busy", cmd_ready, 0);
      step();
    end
    wvalid = 1'b0;
    #1;
    check_eq("wr_ready_back", cmd_ready, 1);
    check_eq("wr_rdowr_off", rd_o_wr[1][2], 0);

    rd_burst("rd_a", 10'h3FA, dat_a);

    // WR with a 3-cycle wvalid gap after two beats
    begin
      int n0;
      int beat;
      issue(2'd2, 2'd1, 2'd2, 5'd0, 10'h015);
      n0 = cyc;
      beat = 0;
      for (int c = 0; c < 11; c++) begin
        wvalid = !(c >= 2 && c < 5);
        wdata  = dat_b[beat];
        #1;
        if (wvalid) begin
          check_eq("gap_col", column[1][2], col_b[beat]);
          check_eq("gap_rdowr", rd_o_wr[1][2], 1);
          beat++;
        end else begin
          check_eq("gap_hold_col", column[1][2], 10'h017);
          check_eq("gap_idle_rdowr", rd_o_wr[1][2], 0);
          check_eq("gap_wready", wready, 1);
        end
        step();
      end
      wvalid = 1'b0;
      check_eq("gap_ready", cmd_ready, 1);
      check_eq("gap_ready_cyc", cyc, n0 + 11);
    end
    rd_burst("rd_b", 10'h015, dat_b);

    // Illegal commands
    issue(2'd1, 2'd0, 2'd0, 5'd0, 10'h000);
    check_eq("rd_closed_err", cmd_err, 1);
    check_eq("rd_closed_ready", cmd_ready, 1);
    check_eq("rd_closed_wready", wready, 0);
    step();
    check_eq("err_one_cycle", cmd_err, 0);
    check_eq("rd_closed_no_rvalid", rvalid, 0);
    issue(2'd0, 2'd1, 2'd2, 5'd7, 10'h000);
    check_eq("act_open_err", cmd_err, 1);
    check_eq("act_open_row", row[1][2], 5);
    issue(2'd3, 2'd3, 2'd3, 5'd0, 10'h000);
    check_eq("pre_closed_err", cmd_err, 0);

    // Reset during beat 4 of a RD
    rq.delete();
    rc.delete();
    issue(2'd1, 2'd1, 2'd2, 5'd0, 10'h3FA);
    repeat (4) step();
    check_eq("mid_col", column[1][2], 10'h3FE);
    rst = 1'b1;
    step();
    check_eq("mid_rst_ready", cmd_ready, 0);
    check_eq("mid_rst_rvalid", rvalid, 0);
    check_eq("mid_rst_rdata", rdata, 0);
    check_eq("mid_rst_row", row[1][2], 0);
    check_eq("mid_rst_col", column[1][2], 0);
    check_eq("mid_rst_rdowr", rd_o_wr[1][2], 0);
    n_before = rq.size();
    check_eq("mid_beats_before", n_before, 3);
    rst = 1'b0;
    repeat (12) step();
    check_eq("mid_no_more_rvalid", rq.size(), n_before);
    issue(2'd1, 2'd1, 2'd2, 5'd0, 10'h3FA);
    check_eq("post_rst_closed_err", cmd_err, 1);
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
